// File: rtl/dm_bank_pkg.sv
// dm_bank_pkg: constants and helpers shared by the M-stage data memory.
//   DM_DEPTH / DM_AW : default array depth (32-bit words) and word-index width
//   ld_sel_e         : load-width codes driven by the pipeline
//   dm_state_e       : clear-sweep / normal-operation state codes
//   merge_lanes()    : byte-lane merge of new store data into an old word
package dm_bank_pkg;

  localparam int DM_DEPTH = 3072;
  localparam int DM_AW    = $clog2(DM_DEPTH);

  typedef enum logic [1:0] {
    LD_WORD = 2'b00,
    LD_HALF = 2'b01,
    LD_BYTE = 2'b10
  } ld_sel_e;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } dm_state_e;

  // Replace every lane of old_word whose enable bit is set with the same
  // lane of new_word; disabled lanes keep the old contents.
  function automatic logic [31:0] merge_lanes(input logic [31:0] old_word,
                                              input logic [31:0] new_word,
                                              input logic [3:0]  be);
    logic [31:0] m;
    m = old_word;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) begin
        m[8*i +: 8] = new_word[8*i +: 8];
      end else begin
        m[8*i +: 8] = old_word[8*i +: 8];
      end
    end
    return m;
  endfunction

endpackage

// File: rtl/dm_bank_if.sv
// dm_bank_if: M-stage <-> data memory bus.
//   master : pipeline side (drives address, store data, byte enables,
//            load width/sign and PC; receives read data, busy and trace)
//   slave  : memory side (dm_bank)
interface dm_bank_if;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  byteen;
  logic [1:0]  ld_sel;
  logic        ld_sign;
  logic [31:0] pc;
  logic [31:0] rdata;
  logic        busy;
  logic        trace_we;
  logic [31:0] trace_pc;
  logic [31:0] trace_addr;
  logic [31:0] trace_data;

  modport master (
    output addr, wdata, byteen, ld_sel, ld_sign, pc,
    input  rdata, busy, trace_we, trace_pc, trace_addr, trace_data
  );

  modport slave (
    input  addr, wdata, byteen, ld_sel, ld_sign, pc,
    output rdata, busy, trace_we, trace_pc, trace_addr, trace_data
  );
endinterface

// File: rtl/dm_load_ext.sv
// dm_load_ext: purely combinational load extractor.
//   word    in  32  full memory word
//   addr_lo in  2   byte offset within the word
//   ld_sel  in  2   load width (word / half / byte; 11 behaves as word)
//   ld_sign in  1   1 = sign-extend half/byte, 0 = zero-extend
//   rdata   out 32  extended load result
module dm_load_ext
  import dm_bank_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  ld_sel,
  input  logic        ld_sign,
  output logic [31:0] rdata
);

  logic [15:0] half_s;
  logic [7:0]  byte_s;

  // Select the addressed half/byte and extend it to 32 bits.
  always_comb begin
    half_s = 16'h0000;
    byte_s = 8'h00;
    rdata  = word;

    if (addr_lo[1]) begin
      half_s = word[31:16];
    end else begin
      half_s = word[15:0];
    end

    case (addr_lo)
      2'b00:   byte_s = word[7:0];
      2'b01:   byte_s = word[15:8];
      2'b10:   byte_s = word[23:16];
      2'b11:   byte_s = word[31:24];
      default: byte_s = word[7:0];
    endcase

    case (ld_sel)
      LD_HALF: rdata = {{16{ld_sign & half_s[15]}}, half_s};
      LD_BYTE: rdata = {{24{ld_sign & byte_s[7]}}, byte_s};
      default: rdata = word;   // word load, and the unused 11 code
    endcase
  end

endmodule

// File: rtl/dm_bank.sv
// dm_bank: word-organised M-stage data memory with byte-masked writes.
//   clk   in  system clock, all state on the rising edge
//   reset in  asynchronous active-high reset; restarts the clear sweep
//   bus   slave modport of dm_bank_if:
//         addr/wdata/byteen/ld_sel/ld_sign/pc from the pipeline,
//         rdata (combinational load data), busy (sweep in progress),
//         trace_we/pc/addr/data (registered record of the last write).
// After reset the array is zeroed one word per cycle; while that runs
// busy is high, reads return 0 and writes are dropped.
module dm_bank
  import dm_bank_pkg::*;
#(
  parameter int DEPTH = DM_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic      clk,
  input  logic      reset,
  dm_bank_if.slave  bus
);

  dm_state_e   state_r;
  dm_state_e   state_nx_s;
  logic [AW-1:0] clr_idx_r;
  logic [AW-1:0] clr_idx_nx_s;

  logic [31:0] mem_r [DEPTH];

  logic [AW-1:0] widx_s;
  logic          in_range_s;
  logic [31:0]   word_s;
  logic          wr_commit_s;
  logic [31:0]   merged_s;

  logic          mem_we_s;
  logic [AW-1:0] mem_widx_s;
  logic [31:0]   mem_wdata_s;

  logic        trace_we_r;
  logic [31:0] trace_pc_r;
  logic [31:0] trace_addr_r;
  logic [31:0] trace_data_r;

  // Address decode, read word and write-commit qualification.
  always_comb begin
    widx_s      = bus.addr[AW+1:2];
    in_range_s  = (bus.addr[31:2] < 30'(DEPTH));
    if ((state_r == ST_RUN) && in_range_s) begin
      word_s = mem_r[widx_s];
    end else begin
      word_s = 32'h0000_0000;
    end
    wr_commit_s = (state_r == ST_RUN) && in_range_s && (bus.byteen != 4'b0000);
    // Merging against the pre-write word also gives the trace its data.
    merged_s    = merge_lanes(word_s, bus.wdata, bus.byteen);
  end

  // Clear-sweep FSM: next state and next sweep index.
  always_comb begin
    state_nx_s   = state_r;
    clr_idx_nx_s = clr_idx_r;
    case (state_r)
      ST_CLEAR: begin
        if (clr_idx_r == AW'(DEPTH - 1)) begin
          state_nx_s   = ST_RUN;
          clr_idx_nx_s = '0;
        end else begin
          state_nx_s   = ST_CLEAR;
          clr_idx_nx_s = clr_idx_r + AW'(1'b1);
        end
      end
      ST_RUN: begin
        state_nx_s   = ST_RUN;
        clr_idx_nx_s = clr_idx_r;
      end
      default: begin
        state_nx_s   = ST_CLEAR;
        clr_idx_nx_s = '0;
      end
    endcase
  end

  // FSM state and sweep index registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r   <= ST_CLEAR;
      clr_idx_r <= '0;
    end else begin
      state_r   <= state_nx_s;
      clr_idx_r <= clr_idx_nx_s;
    end
  end

  // Single array write port: sweep zeroes during CLEAR, merged store in RUN.
  always_comb begin
    mem_we_s    = 1'b0;
    mem_widx_s  = '0;
    mem_wdata_s = 32'h0000_0000;
    case (state_r)
      ST_CLEAR: begin
        mem_we_s    = 1'b1;
        mem_widx_s  = clr_idx_r;
        mem_wdata_s = 32'h0000_0000;
      end
      ST_RUN: begin
        mem_we_s    = wr_commit_s;
        mem_widx_s  = widx_s;
        mem_wdata_s = merged_s;
      end
      default: begin
        mem_we_s    = 1'b0;
        mem_widx_s  = '0;
        mem_wdata_s = 32'h0000_0000;
      end
    endcase
  end

  // Storage array; contents are defined by the sweep, not by reset.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem_r[mem_widx_s] <= mem_wdata_s;
    end
  end

  // Write-trace record; fields other than trace_we hold between writes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      trace_we_r   <= 1'b0;
      trace_pc_r   <= 32'h0000_0000;
      trace_addr_r <= 32'h0000_0000;
      trace_data_r <= 32'h0000_0000;
    end else if (wr_commit_s) begin
      trace_we_r   <= 1'b1;
      trace_pc_r   <= bus.pc;
      trace_addr_r <= {bus.addr[31:2], 2'b00};
      trace_data_r <= merged_s;
    end else begin
      trace_we_r   <= 1'b0;
    end
  end

  assign bus.busy       = (state_r == ST_CLEAR);
  assign bus.trace_we   = trace_we_r;
  assign bus.trace_pc   = trace_pc_r;
  assign bus.trace_addr = trace_addr_r;
  assign bus.trace_data = trace_data_r;

  dm_load_ext u_load_ext (
    .word    (word_s),
    .addr_lo (bus.addr[1:0]),
    .ld_sel  (bus.ld_sel),
    .ld_sign (bus.ld_sign),
    .rdata   (bus.rdata)
  );

endmodule

// File: tb/tb_dm_bank.sv
// tb_dm_bank: randomized + directed bench for dm_bank against a
// behavioural model (flat word array, sweep countdown, mask arithmetic).
module tb_dm_bank;
  import dm_bank_pkg::*;

  localparam int DEPTH = DM_DEPTH;

  logic clk = 1'b0;
  logic reset;

  dm_bank_if bus ();

  dm_bank u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;
  bit armed       = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] m_mem [DEPTH];
  int          m_sweep;          // cycles of clearing still to go
  logic        m_twe;
  logic [31:0] m_tpc, m_taddr, m_tdata;

  function automatic bit m_inr(input logic [31:0] a);
    return a[31:2] < 30'(DEPTH);
  endfunction

  function automatic int m_idx(input logic [31:0] a);
    return int'(a[31:2]);
  endfunction

  function automatic logic [31:0] m_word(input logic [31:0] a);
    if (m_sweep == 0 && m_inr(a)) return m_mem[m_idx(a)];
    else return 32'h0;
  endfunction

  function automatic logic [31:0] m_merge(input logic [31:0] o, input logic [31:0] n,
                                          input logic [3:0] be);
    logic [31:0] mask;
    mask = 32'h0;
    for (int i = 0; i < 4; i++)
      if (be[i]) mask = mask | (32'hFF << (8 * i));
    return (o & ~mask) | (n & mask);
  endfunction

  function automatic logic [31:0] m_ext(input logic [31:0] w, input logic [1:0] lo,
                                        input logic [1:0] sel, input logic sgn);
    logic [31:0] v;
    if (sel == 2'b01) begin
      v = (w >> (lo[1] ? 16 : 0)) & 32'h0000FFFF;
      if (sgn && v[15]) v = v | 32'hFFFF0000;
    end else if (sel == 2'b10) begin
      v = (w >> (8 * int'(lo))) & 32'h000000FF;
      if (sgn && v[7]) v = v | 32'hFFFFFF00;
    end else begin
      v = w;
    end
    return v;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) m_mem[i] <= 32'h0;
      m_sweep <= DEPTH;
      m_twe   <= 1'b0;
      m_tpc   <= 32'h0;
      m_taddr <= 32'h0;
      m_tdata <= 32'h0;
    end else if (m_sweep > 0) begin
      m_sweep <= m_sweep - 1;
      m_twe   <= 1'b0;
    end else if (bus.byteen != 4'b0000 && m_inr(bus.addr)) begin
      m_mem[m_idx(bus.addr)] <= m_merge(m_mem[m_idx(bus.addr)], bus.wdata, bus.byteen);
      m_twe   <= 1'b1;
      m_tpc   <= bus.pc;
      m_taddr <= bus.addr & 32'hFFFFFFFC;
      m_tdata <= m_merge(m_mem[m_idx(bus.addr)], bus.wdata, bus.byteen);
    end else begin
      m_twe   <= 1'b0;
    end
  end

  // Compare process: every cycle, away from the active edge.
  always @(negedge clk) begin
    if (armed) begin
      chk("busy",       {31'h0, bus.busy},     {31'h0, (m_sweep > 0)});
      chk("rdata",      bus.rdata,
          m_ext(m_word(bus.addr), bus.addr[1:0], bus.ld_sel, bus.ld_sign));
      chk("trace_we",   {31'h0, bus.trace_we}, {31'h0, m_twe});
      chk("trace_pc",   bus.trace_pc,   m_tpc);
      chk("trace_addr", bus.trace_addr, m_taddr);
      chk("trace_data", bus.trace_data, m_tdata);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic drive(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be,
                       input logic [1:0] sel, input logic sgn, input logic [31:0] p);
    bus.addr    = a;
    bus.wdata   = d;
    bus.byteen  = be;
    bus.ld_sel  = sel;
    bus.ld_sign = sgn;
    bus.pc      = p;
  endtask

  task automatic cyc(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be,
                     input logic [1:0] sel, input logic sgn, input logic [31:0] p);
    @(posedge clk);
    #1;
    drive(a, d, be, sel, sgn, p);
    @(negedge clk);
  endtask

  task automatic rd(input logic [31:0] a, input logic [1:0] sel, input logic sgn);
    cyc(a, 32'h0, 4'b0000, sel, sgn, 32'h0);
  endtask

  task automatic rand_drive();
    logic [31:0] a;
    case ($urandom_range(0, 3))
      0:       a = 32'($urandom_range(0, 255));
      1:       a = 32'h2F00 + 32'($urandom_range(0, 511));
      2:       a = $urandom();
      default: a = 32'h40 + 32'($urandom_range(0, 63));
    endcase
    drive(a, $urandom(), 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)),
          1'($urandom_range(0, 1)), $urandom());
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
    drive(32'h0, 32'h0, 4'b0000, 2'b00, 1'b0, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // Count busy cycles after release while throwing random writes at the bank.
  task automatic sweep_count(input int stop_at, output int n);
    n = 0;
    for (int k = 0; k < 5000; k++) begin
      @(negedge clk);
      if (!bus.busy || n == stop_at) break;
      n++;
      @(posedge clk);
      #1;
      rand_drive();
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, vectors %0d", vectors);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset = 1'b1;
    drive(32'h0, 32'h0, 4'b0000, 2'b00, 1'b0, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    armed = 1'b1;
    reset = 1'b0;

    // Reset sweep length and cleared contents.
    sweep_count(-1, n);
    chk("sweep_len", 32'(n), 32'd3072);
    rd(32'h0000_0000, LD_WORD, 1'b0);
    chk("clr_rd_0", bus.rdata, 32'h0000_0000);
    rd(32'h0000_2FFC, LD_WORD, 1'b0);
    chk("clr_rd_top", bus.rdata, 32'h0000_0000);

    // Byte write merged into an existing word.
    cyc(32'h10, 32'h11223344, 4'b1111, LD_WORD, 1'b0, 32'h0000_0100);
    cyc(32'h12, 32'h00AB0000, 4'b0100, LD_WORD, 1'b0, 32'h0000_0104);
    chk("tr_data_w1", bus.trace_data, 32'h11223344);
    rd(32'h10, LD_WORD, 1'b0);
    chk("tr_we_merge",   {31'h0, bus.trace_we}, 32'h1);
    chk("tr_data_merge", bus.trace_data, 32'h11AB3344);
    chk("tr_addr_merge", bus.trace_addr, 32'h0000_0010);
    chk("tr_pc_merge",   bus.trace_pc,   32'h0000_0104);
    chk("rd_merge",      bus.rdata,      32'h11AB3344);
    rd(32'h10, LD_WORD, 1'b0);
    chk("tr_we_drop",    {31'h0, bus.trace_we}, 32'h0);
    chk("tr_data_hold",  bus.trace_data, 32'h11AB3344);

    // Load extraction.
    cyc(32'h20, 32'h80FF7F01, 4'b1111, LD_WORD, 1'b0, 32'h0000_0200);
    rd(32'h22, LD_HALF, 1'b0);  chk("ld_hu_22", bus.rdata, 32'h0000_80FF);
    rd(32'h22, LD_HALF, 1'b1);  chk("ld_hs_22", bus.rdata, 32'hFFFF_80FF);
    rd(32'h20, LD_HALF, 1'b1);  chk("ld_hs_20", bus.rdata, 32'h0000_7F01);
    rd(32'h21, LD_BYTE, 1'b1);  chk("ld_bs_21", bus.rdata, 32'h0000_007F);
    rd(32'h22, LD_BYTE, 1'b1);  chk("ld_bs_22", bus.rdata, 32'hFFFF_FFFF);
    rd(32'h23, LD_BYTE, 1'b0);  chk("ld_bu_23", bus.rdata, 32'h0000_0080);
    rd(32'h23, 2'b11,   1'b1);  chk("ld_sel11", bus.rdata, 32'h80FF_7F01);

    // Range boundary: last word writable, first word past the end is not.
    cyc(32'h2FFC, 32'hCAFEF00D, 4'b1111, LD_WORD, 1'b0, 32'h0000_0300);
    rd(32'h2FFC, LD_WORD, 1'b0);
    chk("top_tr_we", {31'h0, bus.trace_we}, 32'h1);
    chk("top_rd",    bus.rdata, 32'hCAFEF00D);
    cyc(32'h3000, 32'hDEADBEEF, 4'b1111, LD_WORD, 1'b0, 32'h0000_0304);
    rd(32'h3000, LD_WORD, 1'b0);
    chk("oor_tr_we", {31'h0, bus.trace_we}, 32'h0);
    chk("oor_rd",    bus.rdata, 32'h0000_0000);
    rd(32'h0, LD_WORD, 1'b0);
    chk("oor_rd_0",  bus.rdata, 32'h0000_0000);

    // Read during write shows the old contents, new contents next cycle.
    cyc(32'h40, 32'h0000_0001, 4'b1111, LD_WORD, 1'b0, 32'h0000_0400);
    cyc(32'h40, 32'h0000_0002, 4'b1111, LD_WORD, 1'b0, 32'h0000_0404);
    chk("rdw_old", bus.rdata, 32'h0000_0001);
    rd(32'h40, LD_WORD, 1'b0);
    chk("rdw_new", bus.rdata, 32'h0000_0002);

    // Random traffic.
    repeat (3000) begin
      @(posedge clk);
      #1;
      rand_drive();
    end

    // Reset in the middle of a sweep restarts it from index 0.
    do_reset();
    sweep_count(1000, n);
    chk("sweep_part", 32'(n), 32'd1000);
    do_reset();
    sweep_count(-1, n);
    chk("sweep_restart", 32'(n), 32'd3072);
    chk("busy_wr_untraced", {31'h0, bus.trace_we}, 32'h0);
    rd(32'h10, LD_WORD, 1'b0);
    chk("post_clr_10", bus.rdata, 32'h0000_0000);
    rd(32'h40, LD_WORD, 1'b0);
    chk("post_clr_40", bus.rdata, 32'h0000_0000);

    // A little more random traffic after the second sweep.
    repeat (500) begin
      @(posedge clk);
      #1;
      rand_drive();
    end
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/dm_bank.md
Name: dm_bank

Overview:
- Word-organised data memory for the M stage, directly downstream of the store-alignment/byte-enable stage.
- Consumes aligned write data plus a 4-bit byte enable. Performs byte-masked writes and returns load-extended read data to the pipeline.
- After every reset, a sequential clear sweep zeroes the array; `busy` stalls the pipeline while the sweep runs.
- Emits a registered write-trace record for the bench/grader.

Parameters:
- DEPTH, 3072, number of 32-bit words.
- AW, $clog2(DEPTH), word-index width.

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-high reset
- addr  in  32  byte address from M-stage ALU result
- wdata  in  32  store data, already lane-aligned
- byteen  in  4  byte-lane write enables; 0000 = no write
- ld_sel  in  2  load width: Word/Half/Byte
- ld_sign  in  1  1 = sign-extend Half/Byte loads, 0 = zero-extend
- pc  in  32  PC of the M-stage instruction, for trace
- rdata  out  32  load-extended read data (combinational)
- busy  out  1  clear sweep in progress; pipeline must stall
- trace_we  out  1  one-cycle pulse: a write committed last cycle
- trace_pc  out  32  PC of the committed write
- trace_addr  out  32  word-aligned byte address of the committed write
- trace_data  out  32  full merged word after the write

Behaviour:
- States are CLEAR and RUN, with a clr_idx counter of AW bits.
- Reset asserted (async): state=CLEAR, clr_idx=0, busy=1, trace_we=0, trace_pc/addr/data=0.
- Reset asserted mid-sweep or mid-run restarts the sweep at index 0.
- CLEAR, each edge:
  - mem[clr_idx] <= 0 and clr_idx++.
  - At clr_idx==DEPTH-1, write that word and go to RUN on the same edge.
  - The sweep takes exactly DEPTH cycles after reset deasserts. busy drops to 0 in the cycle after the last clear write.
- CLEAR: every byteen write is ignored; rdata=0; trace_we stays 0.
- Word index: widx = addr[AW+1:2]. The address is in range iff addr[31:2] < DEPTH.
- RUN write (byteen!=0, in range), at the edge:
  - for each lane i with byteen[i]=1: mem[widx][8i+7:8i] <= wdata[8i+7:8i]; other lanes keep their value.
- Out-of-range write: no array change, trace_we=0.
- Trace after a committed write, registered at the same edge:
  - trace_we=1, trace_pc=pc, trace_addr={addr[31:2],2'b00}.
  - trace_data = old word with the enabled lanes replaced.
  - Next edge with no write: trace_we=0; other trace fields hold.
- Read is combinational: word = mem[widx]; out-of-range or CLEAR gives word=0.
- Read and write to the same word in one cycle: rdata shows the pre-write contents.
- Load extraction:
  - Word: rdata=word; addr[1:0] is ignored (misalignment is handled upstream).
  - Half: h = addr[1] ? word[31:16] : word[15:0]; rdata = {16{ld_sign&h[15]}, h}.
  - Byte: b = word[8*addr[1:0]+7 : 8*addr[1:0]]; rdata = {24{ld_sign&b[7]}, b}.
  - ld_sel=11: rdata=word.
- No other outputs depend on the byteen pattern. Non-contiguous byteen is legal and merged lane-wise.

Decomposition:
- Shared constants header, added to the existing const header:
  - width codes Word=2'b00, Half=2'b01, Byte=2'b10.
  - state codes CLEAR=1'b0, RUN=1'b1.
- One natural sub-module: dm_load_ext. It is the pure combinational word → rdata extractor, with inputs word, addr[1:0], ld_sel, ld_sign.
- The array, clear FSM and trace registers stay in dm_bank.

Test Plan:
- Reset sweep: pulse reset 2 cycles, release → busy=1 for exactly 3072 cycles, then 0. A Word read at addr 0x0 and at 0x2FFC returns 0x00000000.
- Byte write/merge:
  - Setup: Word write 0x11223344 to 0x10 (byteen 1111), then byteen 0100 with wdata 0x00AB0000 to 0x12.
  - Trace: trace_data = 0x11AB3344, trace_addr = 0x10, trace_pc matches.
- Loads:
  - Setup: mem[0x20] = 0x80FF7F01.
  - Half: unsigned at 0x22 → 0x000080FF; signed at 0x22 → 0xFFFF80FF.
  - Byte: signed at 0x21 → 0x0000007F; signed at 0x22 → 0xFFFFFFFF; unsigned at 0x23 → 0x00000080.
- Out of range: Word write 0xDEADBEEF to 0x3000 → trace_we stays 0; read at 0x3000 = 0; read at 0x0 unchanged.
- Read-during-write: mem[0x40] = 0x1, write 0x2 to 0x40 while reading 0x40 → rdata = 0x1 that cycle, 0x2 the next.
- Reset mid-sweep: assert reset at sweep cycle 1000 → busy stays 1, and the sweep completes 3072 cycles after the second release. Writes issued during busy are not stored and not traced.
